// File: rtl/mask_loader.sv
// ============================================================================
// mask_loader : streams bytes into the mask register file, or clears it, and
//               reports the mask weight (popcount of the valid mask bits).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mask_loader #(
    parameter  int MAX_N       = 9,
    parameter  int INPUT_SIZE  = 8,
    localparam int MASK_BITS   = MAX_N * MAX_N,
    localparam int MEM_SIZE    = (MASK_BITS + INPUT_SIZE - 1) / 8,
    localparam int ADDR_BITS   = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1,
    localparam int LAST_BITS   = MASK_BITS - (MEM_SIZE - 1) * INPUT_SIZE,
    localparam int WEIGHT_BITS = $clog2(MASK_BITS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_load,
    input  logic                   start_clear,
    input  logic                   abort,
    input  logic [INPUT_SIZE-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ADDR_BITS-1:0]   mr_addr,
    output logic                   mr_w_en,
    output logic [INPUT_SIZE-1:0]  mr_in,
    output logic [WEIGHT_BITS-1:0] weight,
    output logic                   weight_valid,
    output logic                   busy,
    output logic                   done
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(MEM_SIZE - 1);

    // Keeps only the LAST_BITS valid bits of the final word.
    localparam int LAST_MASK_INT = (LAST_BITS >= INPUT_SIZE) ? -1 : ((1 << LAST_BITS) - 1);
    localparam logic [INPUT_SIZE-1:0] LAST_MASK = INPUT_SIZE'(LAST_MASK_INT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_CLEAR = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [ADDR_BITS-1:0]   cnt;
    logic [WEIGHT_BITS-1:0] acc;
    logic                   at_last;
    logic                   handshake;

    function automatic logic [WEIGHT_BITS-1:0] popcount(input logic [INPUT_SIZE-1:0] b);
        logic [WEIGHT_BITS-1:0] n;
        n = '0;
        for (int i = 0; i < INPUT_SIZE; i++) begin
            n = n + WEIGHT_BITS'(b[i]);
        end
        return n;
    endfunction

    assign at_last   = (cnt == LAST_ADDR);
    assign handshake = in_valid && in_ready;
    assign done      = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        mr_w_en    = 1'b0;
        mr_addr    = '0;
        mr_in      = '0;
        case (state)
            S_IDLE: begin
                if (start_clear) begin
                    state_next = S_CLEAR;
                end else if (start_load) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                mr_addr = cnt;
                if (abort) begin
                    state_next = S_IDLE;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        mr_w_en = 1'b1;
                        mr_in   = at_last ? (in_data & LAST_MASK) : in_data;
                        if (at_last) begin
                            state_next = S_DONE;
                        end
                    end
                end
            end
            S_CLEAR: begin
                mr_addr = cnt;
                if (abort) begin
                    state_next = S_IDLE;
                end else begin
                    mr_w_en = 1'b1;
                    if (at_last) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // cnt holds at the last address: the state machine leaves before it could wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            acc          <= '0;
            weight       <= '0;
            weight_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_clear || start_load) begin
                        cnt          <= '0;
                        acc          <= '0;
                        weight_valid <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (handshake) begin
                        acc <= acc + popcount(mr_in);
                        if (!at_last) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    if (!abort && !at_last) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    weight       <= acc;
                    weight_valid <= 1'b1;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mask_loader.sv
// ============================================================================
// tb_mask_loader : directed + randomized bench; expected writes and weight are
//                  derived from the assembled MASK_BITS-bit mask vector.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mask_loader;

    localparam int MAX_N       = 9;
    localparam int INPUT_SIZE  = 8;
    localparam int MASK_BITS   = MAX_N * MAX_N;
    localparam int MEM_SIZE    = (MASK_BITS + INPUT_SIZE - 1) / 8;
    localparam int ADDR_BITS   = $clog2(MEM_SIZE);
    localparam int WEIGHT_BITS = $clog2(MASK_BITS + 1);

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start_load = 1'b0;
    logic                   start_clear = 1'b0;
    logic                   abort = 1'b0;
    logic [INPUT_SIZE-1:0]  in_data = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [ADDR_BITS-1:0]   mr_addr;
    logic                   mr_w_en;
    logic [INPUT_SIZE-1:0]  mr_in;
    logic [WEIGHT_BITS-1:0] weight;
    logic                   weight_valid;
    logic                   busy;
    logic                   done;

    mask_loader #(.MAX_N(MAX_N), .INPUT_SIZE(INPUT_SIZE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_load   (start_load),
        .start_clear  (start_clear),
        .abort        (abort),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mr_addr      (mr_addr),
        .mr_w_en      (mr_w_en),
        .mr_in        (mr_in),
        .weight       (weight),
        .weight_valid (weight_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference state: what weight / weight_valid should read between sequences.
    int ref_weight = 0;
    bit ref_wv     = 1'b0;

    logic [7:0] load_bytes [MEM_SIZE];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Expected register word i is the slice of the mask vector; bits past MASK_BITS are zero.
    function automatic logic [7:0] expected_word(input int i);
        logic [MASK_BITS-1:0] vec;
        logic [7:0]           w;
        vec = '0;
        for (int k = 0; k < MEM_SIZE; k++)
            for (int b = 0; b < 8; b++)
                if (k * 8 + b < MASK_BITS) vec[k*8+b] = load_bytes[k][b];
        w = '0;
        for (int b = 0; b < 8; b++)
            if (i * 8 + b < MASK_BITS) w[b] = vec[i*8+b];
        return w;
    endfunction

    function automatic int expected_weight();
        int n;
        n = 0;
        for (int i = 0; i < MEM_SIZE; i++) n += $countones(expected_word(i));
        return n;
    endfunction

    task automatic feed_bytes(input int first, input int count, input int max_gap);
        for (int i = first; i < first + count; i++) begin
            int gaps;
            gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gaps; g++) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
                check("gap_wen", 32'(mr_w_en), 32'd0);
                check("gap_ready", 32'(in_ready), 32'd1);
                next_cycle();
            end
            in_valid = 1'b1;
            in_data  = load_bytes[i];
            @(negedge clk);
            check("ld_wen", 32'(mr_w_en), 32'd1);
            check("ld_addr", 32'(mr_addr), 32'(i));
            check("ld_data", 32'(mr_in), 32'(expected_word(i)));
            if (i == 0) begin
                check("ld_busy", 32'(busy), 32'd1);
                check("ld_wv_cleared", 32'(weight_valid), 32'd0);
            end
            next_cycle();
        end
        in_valid = 1'b0;
    endtask

    task automatic begin_load();
        start_load = 1'b1;
        next_cycle();
        start_load = 1'b0;
        ref_wv     = 1'b0;
    endtask

    task automatic finish_check(input string tag);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        next_cycle();
        @(negedge clk);
        check({tag, "_done_drop"}, 32'(done), 32'd0);
        check({tag, "_weight"}, 32'(weight), 32'(ref_weight));
        check({tag, "_wv"}, 32'(weight_valid), 32'(ref_wv));
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic run_load(input int max_gap);
        begin_load();
        feed_bytes(0, MEM_SIZE, max_gap);
        ref_weight = expected_weight();
        ref_wv     = 1'b1;
        finish_check("load");
        next_cycle();
    endtask

    task automatic run_clear(input bit both_starts, input bit mid_load);
        start_clear = 1'b1;
        start_load  = both_starts;
        next_cycle();
        start_clear = 1'b0;
        start_load  = 1'b0;
        for (int i = 0; i < MEM_SIZE; i++) begin
            start_load = mid_load && (i == 5);
            in_valid   = 1'($urandom);
            @(negedge clk);
            check("clr_wen", 32'(mr_w_en), 32'd1);
            check("clr_addr", 32'(mr_addr), 32'(i));
            check("clr_data", 32'(mr_in), 32'd0);
            check("clr_ready", 32'(in_ready), 32'd0);
            next_cycle();
        end
        start_load = 1'b0;
        in_valid   = 1'b0;
        ref_weight = 0;
        ref_wv     = 1'b1;
        finish_check("clear");
        next_cycle();
    endtask

    task automatic random_bytes();
        for (int i = 0; i < MEM_SIZE; i++) load_bytes[i] = 8'($urandom);
    endtask

    initial begin
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_weight", 32'(weight), 32'd0);
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        check("idle_wen", 32'(mr_w_en), 32'd0);
        check("idle_wv", 32'(weight_valid), 32'd0);
        next_cycle();

        // Back-to-back all-ones load: last word keeps only its valid bit.
        for (int i = 0; i < MEM_SIZE; i++) load_bytes[i] = 8'hFF;
        run_load(0);

        // Sparse pattern with stalls; padding bits of the last byte are dropped.
        for (int i = 0; i < MEM_SIZE; i++) load_bytes[i] = 8'h00;
        load_bytes[0] = 8'h01;
        load_bytes[1] = 8'h03;
        load_bytes[MEM_SIZE-1] = 8'hFE;
        run_load(3);

        run_clear(1'b0, 1'b0);
        run_clear(1'b1, 1'b1);

        for (int r = 0; r < 4; r++) begin
            random_bytes();
            run_load(r % 4);
        end

        // Abort after five handshakes with data still offered.
        random_bytes();
        begin_load();
        feed_bytes(0, 5, 1);
        in_valid = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        check("abort_wen", 32'(mr_w_en), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd0);
        next_cycle();
        abort    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_wv", 32'(weight_valid), 32'd0);
        check("abort_weight_held", 32'(weight), 32'(ref_weight));
        next_cycle();
        random_bytes();
        run_load(2);

        // Asynchronous reset in the middle of a load.
        random_bytes();
        begin_load();
        feed_bytes(0, 4, 0);
        in_valid = 1'b1;
        in_data  = load_bytes[4];
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_wen", 32'(mr_w_en), 32'd0);
        check("arst_addr", 32'(mr_addr), 32'd0);
        check("arst_data", 32'(mr_in), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_weight", 32'(weight), 32'd0);
        check("arst_wv", 32'(weight_valid), 32'd0);
        ref_weight = 0;
        ref_wv     = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'd0);
        check("post_rst_wen", 32'(mr_w_en), 32'd0);
        next_cycle();
        in_valid = 1'b0;
        random_bytes();
        run_load(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
